// File: rtl/em_elastic_stage_reg_if.sv
// Handshake and data bundle between execute and memory around the EX/MEM elastic stage.
// The master modport is the environment view, and the slave modport is the stage view.
interface em_elastic_stage_reg_if #(
  parameter int unsigned CTRL_W    = 21,
  parameter int unsigned PAYLOAD_W = 89
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CTRL_W-1:0]    ctrl_in;
  logic [PAYLOAD_W-1:0] payload_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [CTRL_W-1:0]    ctrl_out;
  logic [PAYLOAD_W-1:0] payload_out;

  modport master (
    output in_valid, ctrl_in, payload_in, out_ready,
    input  in_ready, out_valid, ctrl_out, payload_out
  );

  modport slave (
    input  in_valid, ctrl_in, payload_in, out_ready,
    output in_ready, out_valid, ctrl_out, payload_out
  );
endinterface

// File: rtl/em_elastic_stage_reg.sv
// EX/MEM elastic pipeline register with a main entry and a skid entry.
// in_ready is a flop, so a memory-side stall never reaches execute combinationally.
// Supports a synchronous flush. A bubble (ctrl_out = 0) is presented on every invalid cycle.
// Optional stall counter: define EM_STALL_CNT_EN. Without it, stall_count is tied to 0.
module em_elastic_stage_reg #(
  parameter int unsigned CTRL_W    = 21,
  parameter int unsigned PAYLOAD_W = 89,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  em_elastic_stage_reg_if.slave bus,
  output logic [CNT_W-1:0]     stall_count
);

  // Occupancy encoded as {main_v, skid_v}
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StSkid  = 2'b01;
  localparam logic [1:0] StHalf  = 2'b10;
  localparam logic [1:0] StFull  = 2'b11;

  logic                 main_v_q, main_v_d;
  logic                 skid_v_q, skid_v_d;
  logic                 in_ready_q;
  logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
  logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d;
  logic [PAYLOAD_W-1:0] skid_pl_q, skid_pl_d;
  logic                 accept;
  logic                 pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = main_v_q & bus.out_ready;

  // Next-state for occupancy and entry data; flush drops everything but leaves data regs alone
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_ctrl_d = main_ctrl_q;
    main_pl_d   = main_pl_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_pl_d   = skid_pl_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case ({main_v_q, skid_v_q})
        StEmpty: begin
          if (accept) begin
            main_v_d    = 1'b1;
            main_ctrl_d = bus.ctrl_in;
            main_pl_d   = bus.payload_in;
          end
        end
        StHalf: begin
          if (accept && pop) begin
            main_ctrl_d = bus.ctrl_in;
            main_pl_d   = bus.payload_in;
          end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = bus.ctrl_in;
            skid_pl_d   = bus.payload_in;
          end else if (pop) begin
            main_v_d = 1'b0;
          end
        end
        StFull: begin
          // in_ready is low here, so only a pop can move the state
          if (pop) begin
            skid_v_d    = 1'b0;
            main_ctrl_d = skid_ctrl_q;
            main_pl_d   = skid_pl_q;
          end
        end
        StSkid: begin
          // Unreachable; recover to empty
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_pl_q   <= '0;
      skid_ctrl_q <= '0;
      skid_pl_q   <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= ~skid_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_pl_q   <= main_pl_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_pl_q   <= skid_pl_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_v_q;
  assign bus.ctrl_out    = main_v_q ? main_ctrl_q : '0;
  assign bus.payload_out = main_pl_q;

`ifdef EM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles the head is held by downstream; only reset clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (main_v_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

  skid_only_unreachable_a: assert property (@(posedge clk) disable iff (!reset)
    !(skid_v_q && !main_v_q));

endmodule

// File: tb/tb_em_elastic_stage_reg.sv
// Self-checking bench for em_elastic_stage_reg: occupancy model plus ctrl/payload scoreboard.
module tb_em_elastic_stage_reg;
  localparam int unsigned CW = 21;
  localparam int unsigned PW = 89;
  localparam int unsigned NW = 16;
  localparam int unsigned StallMax = (1 << NW) - 1;
`ifdef EM_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [NW-1:0] stall_count;

  em_elastic_stage_reg_if #(.CTRL_W(CW), .PAYLOAD_W(PW)) bus_if ();

  em_elastic_stage_reg #(.CTRL_W(CW), .PAYLOAD_W(PW), .CNT_W(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus_if),
    .stall_count (stall_count)
  );

`ifdef EM_STALL_CNT_EN
  // Narrow-counter copy fed the same stimulus, for saturation
  logic [2:0] stall_count_s;
  em_elastic_stage_reg_if #(.CTRL_W(CW), .PAYLOAD_W(PW)) bus_s ();
  assign bus_s.in_valid   = bus_if.in_valid;
  assign bus_s.ctrl_in    = bus_if.ctrl_in;
  assign bus_s.payload_in = bus_if.payload_in;
  assign bus_s.out_ready  = bus_if.out_ready;
  em_elastic_stage_reg #(.CTRL_W(CW), .PAYLOAD_W(PW), .CNT_W(3)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus_s),
    .stall_count (stall_count_s)
  );
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: entry count, stall count, and the FIFO of expected heads
  int               m_cnt = 0;
  int unsigned      m_stall = 0;
  logic [CW-1:0]    sb_ctrl[$];
  logic [PW-1:0]    sb_pl[$];

  // Apply inputs for one cycle (caller is at a negedge)
  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [CW-1:0] c,
                       input logic ordy);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    reset = rst;
    flush = fl;
    bus_if.in_valid   = iv;
    bus_if.ctrl_in    = c;
    bus_if.payload_in = r[PW-1:0];
    bus_if.out_ready  = ordy;
  endtask

  // Update the model for the coming edge, then move to the next negedge
  task automatic advance();
    bit acc;
    bit pp;
    acc = bus_if.in_valid && (m_cnt != 2);
    pp  = (m_cnt > 0) && bus_if.out_ready;
    if (!reset) begin
      m_cnt = 0;
      m_stall = 0;
      sb_ctrl.delete();
      sb_pl.delete();
    end else begin
      if (StallEn && (m_cnt > 0) && !bus_if.out_ready && (m_stall < StallMax)) m_stall++;
      if (pp) begin
        void'(sb_ctrl.pop_front());
        void'(sb_pl.pop_front());
      end
      if (flush) begin
        m_cnt = 0;
        sb_ctrl.delete();
        sb_pl.delete();
      end else begin
        if (acc) begin
          sb_ctrl.push_back(bus_if.ctrl_in);
          sb_pl.push_back(bus_if.payload_in);
        end
        m_cnt = m_cnt + int'(acc) - int'(pp);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b1, 21'h1ABCD, 1'b0);
    advance();
    drive(1'b0, 1'b0, 1'b1, 21'h1ABCD, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.ctrl_out !== '0) begin
      errors++; $display("FAIL reset_ctrl_out: got %h expected 0", bus_if.ctrl_out);
    end
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
    end
    checks++;
    if (bus_if.payload_out !== '0) begin
      errors++; $display("FAIL reset_payload: got %h expected 0", bus_if.payload_out);
    end
    checks++;
    if (stall_count !== '0) begin
      errors++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
    end
    advance();
  endtask

  task automatic test_streaming();
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive(1'b1, 1'b0, cyc < 5, CW'(cyc + 1), 1'b1);
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready cyc%0d: got %b expected 1", cyc, bus_if.in_ready);
      end
      checks++;
      if (bus_if.out_valid !== (cyc >= 1 && cyc <= 5)) begin
        errors++; $display("FAIL stream_out_valid cyc%0d: got %b expected %b", cyc,
                           bus_if.out_valid, (cyc >= 1 && cyc <= 5));
      end
      if (cyc >= 1 && cyc <= 5) begin
        checks++;
        if (bus_if.ctrl_out !== CW'(cyc)) begin
          errors++; $display("FAIL stream_ctrl cyc%0d: got %h expected %h", cyc, bus_if.ctrl_out,
                             CW'(cyc));
        end
        checks++;
        if (bus_if.payload_out !== sb_pl[0]) begin
          errors++; $display("FAIL stream_payload cyc%0d: got %h expected %h", cyc,
                             bus_if.payload_out, sb_pl[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    logic [CW-1:0] seen[$];
    logic [CW-1:0] exp_seq[3];
    logic          iv_t[8];
    logic [CW-1:0] c_t[8];
    logic          or_t[8];
    exp_seq = '{21'h0A, 21'h0B, 21'h0C};
    iv_t = '{1, 1, 1, 1, 0, 1, 0, 0};
    c_t  = '{21'h0A, 21'h0B, 21'h0C, 21'h0C, 21'h0, 21'h0C, 21'h0, 21'h0};
    or_t = '{0, 0, 0, 0, 1, 1, 1, 1};
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b1, 1'b0, iv_t[cyc], c_t[cyc], or_t[cyc]);
      checks++;
      if (bus_if.in_ready !== (m_cnt != 2)) begin
        errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, bus_if.in_ready,
                           (m_cnt != 2));
      end
      checks++;
      if (bus_if.out_valid !== (m_cnt > 0)) begin
        errors++; $display("FAIL bp_out_valid cyc%0d: got %b expected %b", cyc, bus_if.out_valid,
                           (m_cnt > 0));
      end
      if (m_cnt > 0) begin
        checks++;
        if (bus_if.ctrl_out !== sb_ctrl[0] || bus_if.payload_out !== sb_pl[0]) begin
          errors++; $display("FAIL bp_head cyc%0d: got %h/%h expected %h/%h", cyc,
                             bus_if.ctrl_out, bus_if.payload_out, sb_ctrl[0], sb_pl[0]);
        end
        if (or_t[cyc]) seen.push_back(bus_if.ctrl_out);
      end
      advance();
    end
    checks++;
    if (seen.size() != 3) begin
      errors++; $display("FAIL bp_count: got %0d outputs expected 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] !== exp_seq[i]) begin
          errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [PW-1:0] a_pl;
    drive(1'b1, 1'b0, 1'b1, 21'h0A, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 21'h0B, 1'b0);
    advance();
    // Flush with C offered and the head being popped
    drive(1'b1, 1'b1, 1'b1, 21'h0C, 1'b1);
    a_pl = sb_pl[0];
    checks++;
    if (bus_if.ctrl_out !== 21'h0A || bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_pre: got ctrl %h rdy %b expected ctrl 0a rdy 0",
                         bus_if.ctrl_out, bus_if.in_ready);
    end
    advance();
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.ctrl_out !== '0) begin
        errors++; $display("FAIL flush_empty cyc%0d: got valid %b ctrl %h expected 0/0", cyc,
                           bus_if.out_valid, bus_if.ctrl_out);
      end
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
        errors++; $display("FAIL flush_in_ready cyc%0d: got %b expected 1", cyc, bus_if.in_ready);
      end
      checks++;
      if (bus_if.payload_out !== a_pl) begin
        errors++; $display("FAIL flush_payload_held cyc%0d: got %h expected %h", cyc,
                           bus_if.payload_out, a_pl);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 21'h11, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 21'h12, 1'b0);
    advance();
    drive(1'b0, 1'b1, 1'b1, 21'h13, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: got valid %b rdy %b expected 0/1", bus_if.out_valid,
                         bus_if.in_ready);
    end
    checks++;
    if (bus_if.payload_out !== '0 || bus_if.ctrl_out !== '0) begin
      errors++; $display("FAIL rstmid_data: got %h/%h expected 0/0", bus_if.ctrl_out,
                         bus_if.payload_out);
    end
    checks++;
    if (stall_count !== '0) begin
      errors++; $display("FAIL rstmid_stall: got %0d expected 0", stall_count);
    end
    advance();
  endtask

  task automatic test_stall_count();
    drive(1'b1, 1'b0, 1'b1, 21'h55, 1'b0);
    advance();
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (stall_count !== NW'(StallEn ? 7 : 0)) begin
      errors++; $display("FAIL stall_7: got %0d expected %0d", stall_count, StallEn ? 7 : 0);
    end
    advance();
    for (int cyc = 0; cyc < 2; cyc++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (stall_count !== NW'(StallEn ? 10 : 0)) begin
      errors++; $display("FAIL stall_10: got %0d expected %0d", stall_count, StallEn ? 10 : 0);
    end
`ifdef EM_STALL_CNT_EN
    checks++;
    if (stall_count_s !== 3'd7) begin
      errors++; $display("FAIL stall_saturate: got %0d expected 7", stall_count_s);
    end
`endif
    checks++;
    if (bus_if.ctrl_out !== 21'h55) begin
      errors++; $display("FAIL stall_head: got %h expected 55", bus_if.ctrl_out);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (cyc < 80) begin
        drive(1'b1, 1'b0, $urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 3) != 0);
      end else begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      end
      checks++;
      if (bus_if.out_valid !== (m_cnt > 0) || bus_if.in_ready !== (m_cnt != 2)) begin
        errors++; $display("FAIL b2b_flags cyc%0d: got valid %b rdy %b expected %b %b", cyc,
                           bus_if.out_valid, bus_if.in_ready, (m_cnt > 0), (m_cnt != 2));
      end
      checks++;
      if (m_cnt > 0) begin
        if (bus_if.ctrl_out !== sb_ctrl[0] || bus_if.payload_out !== sb_pl[0]) begin
          errors++; $display("FAIL b2b_head cyc%0d: got %h/%h expected %h/%h", cyc,
                             bus_if.ctrl_out, bus_if.payload_out, sb_ctrl[0], sb_pl[0]);
        end
      end else if (bus_if.ctrl_out !== '0) begin
        errors++; $display("FAIL b2b_bubble cyc%0d: got %h expected 0", cyc, bus_if.ctrl_out);
      end
      checks++;
      if (stall_count !== NW'(m_stall)) begin
        errors++; $display("FAIL b2b_stall cyc%0d: got %0d expected %0d", cyc, stall_count,
                           m_stall);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.ctrl_in    = '0;
    bus_if.payload_in = '0;
    bus_if.out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_stall_count();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
